// File: rtl/cordic_pkg.sv
// cordic_pkg: mode type, arctangent table and inverse-gain constant shared by the CORDIC pipeline.
// The table is scaled so that pi maps to 2^31; atan_entry/kinv_entry rescale it to a datapath width.
package cordic_pkg;

    typedef enum logic {CORDIC_ROT = 1'b0, CORDIC_VEC = 1'b1} cordic_mode_e;

    localparam logic [31:0] ATAN_TAB [31] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756, 32'd42667331,
        32'd21354465,  32'd10679838,  32'd5340245,   32'd2670163,  32'd1335087,
        32'd667544,    32'd333772,    32'd166886,    32'd83443,    32'd41722,
        32'd20861,     32'd10430,     32'd5215,      32'd2608,     32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,       32'd41,
        32'd20,        32'd10,        32'd5,         32'd3,        32'd1,
        32'd1
    };

    // 0.607253 * 2^32, the reciprocal of the CORDIC gain
    localparam logic [31:0] KINV_32 = 32'd2608131775;

    function automatic logic [31:0] rescale(input logic [31:0] v, input int width);
        logic [32:0] r;
        int sh;
        sh = 32 - width;
        r  = {1'b0, v} + ((33'd1 << sh) >> 1);
        return 32'(r >> sh);
    endfunction

    function automatic logic [31:0] atan_entry(input int i, input int width);
        return rescale(ATAN_TAB[i[4:0]], width);
    endfunction

    function automatic logic [31:0] kinv_entry(input int width);
        return rescale(KINV_32, width);
    endfunction

endpackage

// File: rtl/cordic_iter.sv
// cordic_iter: one registered CORDIC micro-rotation by atan(2^-SHIFT); holds all state while en_i is low.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             mode_i,
    input  logic [WIDTH+1:0] x_i,
    input  logic [WIDTH+1:0] y_i,
    input  logic [WIDTH-1:0] z_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic             mode_o,
    output logic [WIDTH+1:0] x_o,
    output logic [WIDTH+1:0] y_o,
    output logic [WIDTH-1:0] z_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam logic [WIDTH-1:0] ATAN = WIDTH'(atan_entry(SHIFT, WIDTH));

    logic             pos;
    logic [WIDTH+1:0] xs, ys, x_d, y_d, x_q, y_q;
    logic [WIDTH-1:0] z_d, z_q;
    logic             valid_q, mode_q;
    logic [TAG_W-1:0] tag_q;

    // pos is d = +1: rotation steers z toward 0, vectoring steers y toward 0
    always_comb begin
        pos = (mode_i == CORDIC_VEC) ? y_i[WIDTH+1] : ~z_i[WIDTH-1];
        xs  = $signed(x_i) >>> SHIFT;
        ys  = $signed(y_i) >>> SHIFT;
        x_d = pos ? x_i - ys : x_i + ys;
        y_d = pos ? y_i + xs : y_i - xs;
        z_d = pos ? z_i - ATAN : z_i + ATAN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            tag_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            mode_q  <= mode_i;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            tag_q   <= tag_i;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined rotation/vectoring CORDIC with quadrant pre-rotation and a global stall.
// Defining CORDIC_GAIN_COMP_EN appends a registered 1/K gain-compensation stage.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 14,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_x,
    output logic [WIDTH+1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic signed [WIDTH-1:0] QTR = WIDTH'(1) << (WIDTH-2);

    logic             stall, en, flip;
    logic [WIDTH+1:0] xe, ye, px_d, py_d, px_q, py_q;
    logic [WIDTH-1:0] pz_d, pz_q;
    logic             pv_q, pm_q;
    logic [TAG_W-1:0] pt_q;

    logic             v_s [STAGES+1];
    logic             m_s [STAGES+1];
    logic [WIDTH+1:0] x_s [STAGES+1];
    logic [WIDTH+1:0] y_s [STAGES+1];
    logic [WIDTH-1:0] z_s [STAGES+1];
    logic [TAG_W-1:0] t_s [STAGES+1];

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    // Folding into |angle| <= pi/2 keeps the iterations inside their convergence range;
    // adding pi is a flip of the angle MSB
    always_comb begin
        xe   = {{2{in_x[WIDTH-1]}}, in_x};
        ye   = {{2{in_y[WIDTH-1]}}, in_y};
        flip = (in_mode == CORDIC_VEC) ? in_x[WIDTH-1]
                                       : ($signed(in_z) > QTR || $signed(in_z) < -QTR);
        px_d = flip ? -xe : xe;
        py_d = flip ? -ye : ye;
        pz_d = flip ? {~in_z[WIDTH-1], in_z[WIDTH-2:0]} : in_z;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= 1'b0;
            pm_q <= 1'b0;
            px_q <= '0;
            py_q <= '0;
            pz_q <= '0;
            pt_q <= '0;
        end else if (en) begin
            pv_q <= in_valid;
            pm_q <= in_mode;
            px_q <= px_d;
            py_q <= py_d;
            pz_q <= pz_d;
            pt_q <= in_tag;
        end
    end

    assign v_s[0] = pv_q;
    assign m_s[0] = pm_q;
    assign x_s[0] = px_q;
    assign y_s[0] = py_q;
    assign z_s[0] = pz_q;
    assign t_s[0] = pt_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_iter
        cordic_iter #(.WIDTH(WIDTH), .SHIFT(i), .TAG_W(TAG_W)) u_iter (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en),
            .valid_i (v_s[i]),
            .mode_i  (m_s[i]),
            .x_i     (x_s[i]),
            .y_i     (y_s[i]),
            .z_i     (z_s[i]),
            .tag_i   (t_s[i]),
            .valid_o (v_s[i+1]),
            .mode_o  (m_s[i+1]),
            .x_o     (x_s[i+1]),
            .y_o     (y_s[i+1]),
            .z_o     (z_s[i+1]),
            .tag_o   (t_s[i+1])
        );
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [WIDTH:0]     KINV = (WIDTH+1)'(kinv_entry(WIDTH));
    localparam logic [2*WIDTH+2:0] RND  = (2*WIDTH+3)'(1) << (WIDTH-1);

    logic [2*WIDTH+2:0] gx, gy;
    logic [WIDTH+1:0]   cx_d, cy_d, cx_q, cy_q;
    logic [WIDTH-1:0]   cz_q;
    logic               cv_q;
    logic [TAG_W-1:0]   ct_q;

    always_comb begin
        gx   = $signed(x_s[STAGES]) * $signed(KINV) + $signed(RND);
        gy   = $signed(y_s[STAGES]) * $signed(KINV) + $signed(RND);
        cx_d = gx[2*WIDTH+1:WIDTH];
        cy_d = gy[2*WIDTH+1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q <= 1'b0;
            cx_q <= '0;
            cy_q <= '0;
            cz_q <= '0;
            ct_q <= '0;
        end else if (en) begin
            cv_q <= v_s[STAGES];
            cx_q <= cx_d;
            cy_q <= cy_d;
            cz_q <= z_s[STAGES];
            ct_q <= t_s[STAGES];
        end
    end

    assign out_valid = cv_q;
    assign out_x     = cx_q;
    assign out_y     = cy_q;
    assign out_z     = cz_q;
    assign out_tag   = ct_q;
`else
    assign out_valid = v_s[STAGES];
    assign out_x     = x_s[STAGES];
    assign out_y     = y_s[STAGES];
    assign out_z     = z_s[STAGES];
    assign out_tag   = t_s[STAGES];
`endif

endmodule
